// File: rtl/exp_accel_core.sv
// rtl/exp_accel_core.sv - Avalon-MM square-and-multiply exponentiation engine
module exp_accel_core #(
  parameter int W     = 32,
  parameter int EXP_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int CW = $clog2(W);
  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SQR, S_MUL, S_DONE} state_t;

  state_t           state, state_nx;
  logic             mode_r, irq_en_r, done_r, ovf_r, err_r;
  logic [W-1:0]     base_r, mod_r, result_r, acc;
  logic [EXP_W-1:0] exp_r;
  logic [31:0]      cycles_r, cyc_cnt;
  logic [2*W-1:0]   p;
  logic [CW-1:0]    bit_idx;
  logic [IW-1:0]    exp_idx;
  logic             loaded;

  logic busy, ctrl_wr, start_go, done_clr;
  logic mul_last, exp_bit, last_exp, mbit;
  logic chk_err, chk_one;
  logic [W-1:0]   mcand;
  logic [W+1:0]   m_dbl, m_red1, m_add, m_red2;
  logic [2*W-1:0] p0_next, p_step;

  assign busy     = (state != S_IDLE);
  assign ctrl_wr  = write && (address == 3'd0);
  assign start_go = ctrl_wr && writedata[0] && !busy;
  assign done_clr = write && (address == 3'd1) && writedata[1];
  assign irq      = done_r & irq_en_r;

  // Multiplier is always acc; multiplicand is acc when squaring, BASE when multiplying.
  assign mbit     = acc[bit_idx];
  assign mcand    = (state == S_MUL) ? base_r : acc;
  assign mul_last = loaded && (bit_idx == '0);
  assign exp_bit  = exp_r[exp_idx];
  assign last_exp = (exp_idx == '0);

  // One interleaved shift-add step; the modular path keeps p below MOD after every step.
  always_comb begin
    m_dbl   = {p[W:0], 1'b0};
    m_red1  = (m_dbl >= {2'b00, mod_r}) ? m_dbl - {2'b00, mod_r} : m_dbl;
    m_add   = m_red1 + (mbit ? {2'b00, mcand} : '0);
    m_red2  = (m_add >= {2'b00, mod_r}) ? m_add - {2'b00, mod_r} : m_add;
    p0_next = {p[2*W-2:0], 1'b0} + (mbit ? {{W{1'b0}}, mcand} : '0);
    p_step  = mode_r ? {{(W-2){1'b0}}, m_red2} : p0_next;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; CHECK only screens operands in modular mode.
  always_comb begin
    state_nx = state;
    chk_err  = mode_r && ((mod_r == '0) || (base_r >= mod_r));
    chk_one  = mode_r && (mod_r == W'(1));
    case (state)
      S_IDLE:  if (start_go) state_nx = S_CHECK;
      S_CHECK: state_nx = (chk_err || chk_one) ? S_DONE : S_SQR;
      S_SQR: begin
        if (mul_last) begin
          if (exp_bit)       state_nx = S_MUL;
          else if (last_exp) state_nx = S_DONE;
          else               state_nx = S_SQR;
        end
      end
      S_MUL:   if (mul_last) state_nx = last_exp ? S_DONE : S_SQR;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Host-writable configuration; operands and mode are frozen while a run is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_r   <= '0;
      exp_r    <= '0;
      mod_r    <= '0;
      mode_r   <= 1'b0;
      irq_en_r <= 1'b0;
    end else begin
      if (write && !busy) begin
        case (address)
          3'd2:    base_r <= writedata[W-1:0];
          3'd3:    exp_r  <= writedata[EXP_W-1:0];
          3'd4:    mod_r  <= writedata[W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        irq_en_r <= writedata[2];
        if (!busy) mode_r <= writedata[1];
      end
    end
  end

  // Engine datapath. CHECK doubles as the load cycle of the first multiply,
  // later multiplies spend their first cycle in the state clearing p.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      err_r    <= 1'b0;
      acc      <= '0;
      p        <= '0;
      bit_idx  <= '0;
      exp_idx  <= '0;
      loaded   <= 1'b0;
      cyc_cnt  <= '0;
      result_r <= '0;
      cycles_r <= '0;
    end else begin
      if (done_clr) done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_go) begin
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
            acc     <= W'(1);
            cyc_cnt <= '0;
            loaded  <= 1'b0;
          end
        end
        S_CHECK: begin
          cyc_cnt <= cyc_cnt + 32'd1;
          if (chk_err) begin
            err_r <= 1'b1;
            acc   <= '0;
          end else if (chk_one) begin
            acc <= '0;
          end else begin
            p       <= '0;
            bit_idx <= CW'(W-1);
            loaded  <= 1'b1;
            exp_idx <= IW'(EXP_W-1);
          end
        end
        S_SQR, S_MUL: begin
          cyc_cnt <= cyc_cnt + 32'd1;
          if (!loaded) begin
            p       <= '0;
            bit_idx <= CW'(W-1);
            loaded  <= 1'b1;
          end else begin
            p       <= p_step;
            bit_idx <= bit_idx - CW'(1);
            if (bit_idx == '0) begin
              loaded <= 1'b0;
              acc    <= p_step[W-1:0];
              if (!mode_r && (p_step[2*W-1:W] != '0)) ovf_r <= 1'b1;
              if (((state == S_MUL) || !exp_bit) && !last_exp) exp_idx <= exp_idx - IW'(1);
            end
          end
        end
        S_DONE: begin
          result_r <= acc;
          done_r   <= 1'b1;
          // The count so far excludes the start cycle and this DONE cycle.
          cycles_r <= cyc_cnt + 32'd2;
        end
        default: ;
      endcase
    end
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (read) begin
      case (address)
        3'd0:    readdata <= {29'b0, irq_en_r, mode_r, 1'b0};
        3'd1:    readdata <= {28'b0, err_r, ovf_r, done_r, busy};
        3'd2:    readdata <= 32'(base_r);
        3'd3:    readdata <= 32'(exp_r);
        3'd4:    readdata <= 32'(mod_r);
        3'd5:    readdata <= 32'(result_r);
        3'd6:    readdata <= cycles_r;
        default: readdata <= '0;
      endcase
    end
  end

endmodule
